// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, default
// cycle constants and the counter-width helper.
package pll_rst_pkg;

   localparam int unsigned DEF_RST_PULSE_CYC    = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 40000;
   localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
   localparam int unsigned DEF_MAX_RETRY        = 7;
   localparam int unsigned RETRY_W              = 3;

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } pll_state_e;

   // Width able to hold the largest of the three cycle limits, plus one bit.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $unsigned($clog2(m)) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, resets to 0.
// Ports: clk, rst (async, active-high), d_i (async input), q_o (synced output).
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences the PLL reset and the system reset from the board reference clock.
// Pulses pll_reset, waits for lock (retrying on timeout), requires lock to be
// stable before releasing sys_reset, and restarts on loss of lock.
// Ports:
//   clk        reference clock (same net as PLL clkin)
//   reset      asynchronous, active-high
//   pll_lock   PLL lock, asynchronous to clk
//   pll_reset  PLL reset, active-high
//   sys_reset  system reset, active-high, released synchronously
//   ready      high only in RUN
//   lock_lost  one-cycle pulse when lock drops in RUN
//   retry_cnt  timed-out attempts since the last RUN
//   fail       sticky after MAX_RETRY failed attempts
module pll_reset_sequencer
   import pll_rst_pkg::*;
#(
   parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
   parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
   parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
   parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pll_lock,
   output logic               pll_reset,
   output logic               sys_reset,
   output logic               ready,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic               fail
);

   localparam int unsigned CNT_W = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
   localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

   pll_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
   logic               lock_s;
   logic               pll_reset_q, pll_reset_d;
   logic               sys_reset_q, sys_reset_d;
   logic               ready_q, ready_d;
   logic               lock_lost_q, lock_lost_d;
   logic               fail_q, fail_d;

   sync_2ff u_lock_sync (
      .clk (clk),
      .rst (reset),
      .d_i (pll_lock),
      .q_o (lock_s)
   );

   // Saturating increment of the retry count.
   assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_W'(1);

   // State, retry count and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_PLL_RST;
         retry_q     <= '0;
         pll_reset_q <= 1'b1;
         sys_reset_q <= 1'b1;
         ready_q     <= 1'b0;
         lock_lost_q <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         retry_q     <= retry_d;
         pll_reset_q <= pll_reset_d;
         sys_reset_q <= sys_reset_d;
         ready_q     <= ready_d;
         lock_lost_q <= lock_lost_d;
         fail_q      <= fail_d;
      end
   end

   // Cycle counter, cleared on every state change, parked at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (state_d != state_q) begin
         cnt_q <= '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Next-state logic; a lock seen in the timeout cycle takes priority.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      case (state_q)
         ST_PLL_RST: begin
            if (cnt_q == PULSE_LAST) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_d = ST_STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_PLL_RST;
            end
         end
         ST_STABLE: begin
            if (!lock_s)                  state_d = ST_WAIT_LOCK;
            else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!lock_s) state_d = ST_PLL_RST;
         end
         ST_FAIL: begin
            state_d = ST_FAIL;
         end
         default: begin
            state_d = ST_PLL_RST;
         end
      endcase
      if (state_d == ST_RUN) retry_d = '0;
   end

   // Outputs decoded from the next state so they register cleanly.
   always_comb begin
      pll_reset_d = 1'b0;
      sys_reset_d = 1'b1;
      ready_d     = 1'b0;
      fail_d      = 1'b0;
      case (state_d)
         ST_PLL_RST: pll_reset_d = 1'b1;
         ST_RUN: begin
            sys_reset_d = 1'b0;
            ready_d     = 1'b1;
         end
         ST_FAIL: fail_d = 1'b1;
         default: ;
      endcase
      lock_lost_d = (state_q == ST_RUN) && (state_d == ST_PLL_RST);
   end

   assign pll_reset = pll_reset_q;
   assign sys_reset = sys_reset_q;
   assign ready     = ready_q;
   assign lock_lost = lock_lost_q;
   assign retry_cnt = retry_q;
   assign fail      = fail_q;

endmodule
